// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the timing generator and the drawing logic
// Purpose: carries the pixel strobe, raster counters, visible-window flag, sync pins and frame ticks.
// Signals:
//   pix_en      - one-clk pixel strobe, counters advance on the edge where it is high
//   hCount      - horizontal pixel counter
//   vCount      - vertical line counter
//   bright      - (hCount, vCount) inside the visible window
//   hSync       - active-low horizontal sync (delayed)
//   vSync       - active-low vertical sync (delayed)
//   frame_tick  - one-clk pulse at the start of each frame
//   vblank_tick - one-clk pulse at the start of vertical blanking
// Modports: master (timing generator drives), slave (consumers observe).
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       bright;
  logic       hSync;
  logic       vSync;
  logic       frame_tick;
  logic       vblank_tick;

  modport master (
    output pix_en,
    output hCount,
    output vCount,
    output bright,
    output hSync,
    output vSync,
    output frame_tick,
    output vblank_tick
  );

  modport slave (
    input pix_en,
    input hCount,
    input vCount,
    input bright,
    input hSync,
    input vSync,
    input frame_tick,
    input vblank_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel-rate divider, sync delay and frame ticks
// Purpose: divides clk by DIV into a pixel strobe, runs the H_TOTAL x V_TOTAL raster, decodes the
//          visible window and sync pulses, and delays the sync pins by SYNC_DELAY clocks so they line
//          up with a pipelined rgb path.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   vga   - vga_timing_gen_if.master: pix_en, hCount, vCount, bright, hSync, vSync,
//           frame_tick, vblank_tick
module vga_timing_gen #(
  parameter int DIV         = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 515,
  parameter int SYNC_DELAY  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0]    V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0]    H_VS      = 10'(H_VIS_START);
  localparam logic [9:0]    H_VE      = 10'(H_VIS_END);
  localparam logic [9:0]    V_VS      = 10'(V_VIS_START);
  localparam logic [9:0]    V_VE      = 10'(V_VIS_END);
  localparam logic [9:0]    V_BLK_PRE = 10'(V_VIS_END - 1);

  logic [DW-1:0] div_q;
  logic          pix_en;
  logic [9:0]    h_q;
  logic [9:0]    v_q;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic          h_wrap;
  logic          frame_start;
  logic          vblank_start;
  logic          bright_nxt;
  logic          bright_q;
  logic          hs_raw;
  logic          vs_raw;
  logic          frame_tick_q;
  logic          vblank_tick_q;

  // Pixel-rate divider; with DIV=1 div_q is pinned at 0 so pix_en stays high.
  assign pix_en = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (pix_en) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Next raster position. Equals the current position on non-pixel clocks, so
  // the decode registers below can load every clock and still track the counters.
  always_comb begin
    h_nxt  = h_q;
    v_nxt  = v_q;
    h_wrap = 1'b0;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_nxt  = '0;
        h_wrap = 1'b1;
        v_nxt  = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_nxt = h_q + 10'd1;
      end
    end
  end

  assign frame_start  = h_wrap && (v_q == V_LAST);
  assign vblank_start = h_wrap && (v_q == V_BLK_PRE);

  assign bright_nxt = (h_nxt >= H_VS) && (h_nxt < H_VE) &&
                      (v_nxt >= V_VS) && (v_nxt < V_VE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      bright_q      <= 1'b0;
      hs_raw        <= 1'b1;
      vs_raw        <= 1'b1;
      frame_tick_q  <= 1'b0;
      vblank_tick_q <= 1'b0;
    end else begin
      h_q           <= h_nxt;
      v_q           <= v_nxt;
      bright_q      <= bright_nxt;
      hs_raw        <= !(h_nxt < H_SYNC_W);
      vs_raw        <= !(v_nxt < V_SYNC_W);
      frame_tick_q  <= frame_start;
      vblank_tick_q <= vblank_start;
    end
  end

  // Sync delay line runs on every clk so the delay is in system clocks, not pixels.
  // It resets to all ones so the pins sit inactive (high) through reset.
  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign vga.hSync = hs_raw;
      assign vga.vSync = vs_raw;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
        end else begin
          hs_pipe[0] <= hs_raw;
          vs_pipe[0] <= vs_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
          end
        end
      end

      assign vga.hSync = hs_pipe[SYNC_DELAY-1];
      assign vga.vSync = vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

  assign vga.pix_en      = pix_en;
  assign vga.hCount      = h_q;
  assign vga.vCount      = v_q;
  assign vga.bright      = bright_q;
  assign vga.frame_tick  = frame_tick_q;
  assign vga.vblank_tick = vblank_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  logic rst_c;

  int checks = 0;
  int errors = 0;

  // a: default timing; b: shrunken raster (DIV=2, 20x10, SYNC_DELAY=3); c: default raster, DIV=1, no delay
  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();
  vga_timing_gen_if ifc ();

  vga_timing_gen u_a (
    .clk   (clk),
    .rst_n (rst_a),
    .vga   (ifa)
  );

  vga_timing_gen #(
    .DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5), .H_VIS_END(17),
    .V_TOTAL(10), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(8), .SYNC_DELAY(3)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_b),
    .vga   (ifb)
  );

  vga_timing_gen #(
    .DIV(1), .SYNC_DELAY(0)
  ) u_c (
    .clk   (clk),
    .rst_n (rst_c),
    .vga   (ifc)
  );

  task automatic test_reset();
    @(negedge clk);
    rst_a = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (ifa.hCount !== 10'd1) begin
      errors++;
      $display("FAIL reset_precount hCount=%0d expected 1", ifa.hCount);
    end
    #2 rst_a = 1'b0;
    #1;
    checks++;
    if ({ifa.hCount, ifa.vCount} !== 20'd0) begin
      errors++;
      $display("FAIL reset_counters h=%0d v=%0d expected 0 0", ifa.hCount, ifa.vCount);
    end
    checks++;
    if ({ifa.bright, ifa.frame_tick, ifa.vblank_tick, ifa.pix_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags bright/ft/vt/pix_en=%b expected 0000",
               {ifa.bright, ifa.frame_tick, ifa.vblank_tick, ifa.pix_en});
    end
    checks++;
    if ({ifa.hSync, ifa.vSync} !== 2'b11) begin
      errors++;
      $display("FAIL reset_sync hSync/vSync=%b expected 11", {ifa.hSync, ifa.vSync});
    end
    @(negedge clk);
    rst_a = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checks++;
      if (ifa.pix_en !== ((n % 4) == 3)) begin
        errors++;
        $display("FAIL cadence_pix_en edge=%0d got %b expected %b", n, ifa.pix_en, ((n % 4) == 3));
      end
      checks++;
      if (ifa.hCount !== 10'(n / 4)) begin
        errors++;
        $display("FAIL cadence_hcount edge=%0d got %0d expected %0d", n, ifa.hCount, n / 4);
      end
    end
  endtask

  task automatic test_sync_default();
    int hs_e[8];
    int vs_e[8];
    int hk = 0;
    int vk = 0;
    logic hs_prev = 1'b1;
    logic vs_prev = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hs_e[i] = -1;
      vs_e[i] = -1;
    end
    for (int n = 1; n <= 6410; n++) begin
      @(negedge clk);
      if (ifa.hSync !== hs_prev) begin
        if (hk < 8) hs_e[hk] = n;
        hk++;
        hs_prev = ifa.hSync;
      end
      if (ifa.vSync !== vs_prev) begin
        if (vk < 8) vs_e[vk] = n;
        vk++;
        vs_prev = ifa.vSync;
      end
      if (n == 3199 || n == 3200) begin
        checks++;
        if (ifa.hCount !== ((n == 3200) ? 10'd0 : 10'd799)) begin
          errors++;
          $display("FAIL line_wrap edge=%0d hCount=%0d", n, ifa.hCount);
        end
      end
    end
    checks++;
    if (hk !== 5) begin
      errors++;
      $display("FAIL hsync_transitions got %0d expected 5", hk);
    end
    checks++;
    if (hs_e[0] !== 3 || hs_e[1] !== 386) begin
      errors++;
      $display("FAIL hsync_first_line fall=%0d rise=%0d expected 3 386", hs_e[0], hs_e[1]);
    end
    checks++;
    if (hs_e[2] !== 3202 || hs_e[3] !== 3586) begin
      errors++;
      $display("FAIL hsync_width fall=%0d rise=%0d expected 3202 3586", hs_e[2], hs_e[3]);
    end
    checks++;
    if (hs_e[4] !== 6402) begin
      errors++;
      $display("FAIL hsync_period next_fall=%0d expected 6402", hs_e[4]);
    end
    checks++;
    if (vk !== 2 || vs_e[0] !== 3 || vs_e[1] !== 6402) begin
      errors++;
      $display("FAIL vsync_low count=%0d fall=%0d rise=%0d expected 2 3 6402", vk, vs_e[0], vs_e[1]);
    end
  endtask

  task automatic test_div1();
    int pe_bad = 0;
    int hs_bad = 0;
    int vs_bad = 0;
    int hs_low = 0;
    checks++;
    if ({ifc.hSync, ifc.vSync} !== 2'b11) begin
      errors++;
      $display("FAIL div1_reset_sync got %b expected 11", {ifc.hSync, ifc.vSync});
    end
    @(negedge clk);
    rst_c = 1'b1;
    for (int n = 1; n <= 28800; n++) begin
      @(negedge clk);
      if (ifc.pix_en !== 1'b1) pe_bad++;
      if (ifc.hSync !== (ifc.hCount >= 10'd96)) hs_bad++;
      if (ifc.vSync !== (ifc.vCount >= 10'd2)) vs_bad++;
      if (n >= 800 && n < 1600 && ifc.hSync === 1'b0) hs_low++;
      case (n)
        27400: begin
          checks++;
          if ({ifc.hCount, ifc.vCount, ifc.bright} !== {10'd200, 10'd34, 1'b0}) begin
            errors++;
            $display("FAIL bright_v34 h=%0d v=%0d bright=%b expected 200 34 0", ifc.hCount, ifc.vCount, ifc.bright);
          end
        end
        28143: begin
          checks++;
          if ({ifc.hCount, ifc.vCount, ifc.bright} !== {10'd143, 10'd35, 1'b0}) begin
            errors++;
            $display("FAIL bright_h143 h=%0d v=%0d bright=%b expected 143 35 0", ifc.hCount, ifc.vCount, ifc.bright);
          end
        end
        28144: begin
          checks++;
          if ({ifc.hCount, ifc.vCount, ifc.bright} !== {10'd144, 10'd35, 1'b1}) begin
            errors++;
            $display("FAIL bright_h144 h=%0d v=%0d bright=%b expected 144 35 1", ifc.hCount, ifc.vCount, ifc.bright);
          end
        end
        28783: begin
          checks++;
          if ({ifc.hCount, ifc.bright} !== {10'd783, 1'b1}) begin
            errors++;
            $display("FAIL bright_h783 h=%0d bright=%b expected 783 1", ifc.hCount, ifc.bright);
          end
        end
        28784: begin
          checks++;
          if ({ifc.hCount, ifc.bright} !== {10'd784, 1'b0}) begin
            errors++;
            $display("FAIL bright_h784 h=%0d bright=%b expected 784 0", ifc.hCount, ifc.bright);
          end
        end
        default: ;
      endcase
    end
    checks++;
    if (pe_bad !== 0) begin
      errors++;
      $display("FAIL div1_pix_en low_cycles=%0d expected 0", pe_bad);
    end
    checks++;
    if (hs_bad !== 0) begin
      errors++;
      $display("FAIL div1_hsync_align bad_cycles=%0d expected 0", hs_bad);
    end
    checks++;
    if (vs_bad !== 0) begin
      errors++;
      $display("FAIL div1_vsync_align bad_cycles=%0d expected 0", vs_bad);
    end
    checks++;
    if (hs_low !== 96) begin
      errors++;
      $display("FAIL div1_hsync_width low=%0d expected 96", hs_low);
    end
  endtask

  task automatic test_raster();
    int ft_e[4];
    int vb_e[4];
    int fk = 0;
    int vk = 0;
    int hs_fall = -1;
    int hs_rise = -1;
    int vs_fall = -1;
    int vs_rise = -1;
    logic hs_prev = 1'b1;
    logic vs_prev = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ft_e[i] = -1;
      vb_e[i] = -1;
    end
    @(negedge clk);
    rst_b = 1'b1;
    for (int n = 1; n <= 1210; n++) begin
      @(negedge clk);
      if (ifb.frame_tick === 1'b1) begin
        if (fk < 4) ft_e[fk] = n;
        fk++;
      end
      if (ifb.vblank_tick === 1'b1) begin
        if (vk < 4) vb_e[vk] = n;
        vk++;
      end
      if (n > 400) begin
        if (hs_prev === 1'b1 && ifb.hSync === 1'b0 && hs_fall < 0) hs_fall = n;
        if (hs_prev === 1'b0 && ifb.hSync === 1'b1 && hs_fall >= 0 && hs_rise < 0) hs_rise = n;
        if (vs_prev === 1'b1 && ifb.vSync === 1'b0 && vs_fall < 0) vs_fall = n;
        if (vs_prev === 1'b0 && ifb.vSync === 1'b1 && vs_fall >= 0 && vs_rise < 0) vs_rise = n;
      end
      hs_prev = ifb.hSync;
      vs_prev = ifb.vSync;
      case (n)
        398: begin
          checks++;
          if ({ifb.hCount, ifb.vCount} !== {10'd19, 10'd9}) begin
            errors++;
            $display("FAIL raster_last h=%0d v=%0d expected 19 9", ifb.hCount, ifb.vCount);
          end
        end
        400: begin
          checks++;
          if ({ifb.hCount, ifb.vCount} !== 20'd0) begin
            errors++;
            $display("FAIL raster_wrap h=%0d v=%0d expected 0 0", ifb.hCount, ifb.vCount);
          end
        end
        100, 128, 130, 152, 154, 300, 340: begin
          checks++;
          if (ifb.bright !== (n == 130 || n == 152 || n == 300)) begin
            errors++;
            $display("FAIL small_bright edge=%0d h=%0d v=%0d got %b", n, ifb.hCount, ifb.vCount, ifb.bright);
          end
        end
        default: ;
      endcase
    end
    checks++;
    if (fk !== 3 || ft_e[0] !== 400 || ft_e[1] !== 800 || ft_e[2] !== 1200) begin
      errors++;
      $display("FAIL frame_tick count=%0d at %0d %0d %0d expected 3 at 400 800 1200", fk, ft_e[0], ft_e[1], ft_e[2]);
    end
    checks++;
    if (vk !== 3 || vb_e[0] !== 320 || vb_e[1] !== 720 || vb_e[2] !== 1120) begin
      errors++;
      $display("FAIL vblank_tick count=%0d at %0d %0d %0d expected 3 at 320 720 1120", vk, vb_e[0], vb_e[1], vb_e[2]);
    end
    checks++;
    if (hs_fall !== 403 || hs_rise !== 409) begin
      errors++;
      $display("FAIL small_hsync fall=%0d rise=%0d expected 403 409", hs_fall, hs_rise);
    end
    checks++;
    if (vs_fall !== 403 || vs_rise !== 483) begin
      errors++;
      $display("FAIL small_vsync fall=%0d rise=%0d expected 403 483", vs_fall, vs_rise);
    end
  endtask

  task automatic test_midframe_reset();
    int early = 0;
    int first = -1;
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    repeat (220) @(negedge clk);
    checks++;
    if ({ifb.hCount, ifb.vCount} !== {10'd10, 10'd5}) begin
      errors++;
      $display("FAIL midframe_pos h=%0d v=%0d expected 10 5", ifb.hCount, ifb.vCount);
    end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({ifb.hCount, ifb.vCount, ifb.frame_tick, ifb.vblank_tick} !== 22'd0) begin
      errors++;
      $display("FAIL midframe_reset h=%0d v=%0d ft=%b vt=%b expected 0 0 0 0",
               ifb.hCount, ifb.vCount, ifb.frame_tick, ifb.vblank_tick);
    end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    for (int n = 1; n <= 810; n++) begin
      @(negedge clk);
      if (ifb.frame_tick === 1'b1) begin
        if (n < 400) early++;
        if (first < 0) first = n;
      end
    end
    checks++;
    if (early !== 0 || first !== 400) begin
      errors++;
      $display("FAIL midframe_no_tick early=%0d first=%0d expected 0 400", early, first);
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    test_reset();
    test_sync_default();
    test_raster();
    test_midframe_reset();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
